// File: rtl/thread_issue_arbiter_if.sv
// Issue-arbiter request/grant bundle. The arbiter sits on the slave side,
// and the thread-select stage driving requests sits on the master side.
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

interface thread_issue_arbiter_if #(
  parameter int unsigned NUM_THREADS  = `THREADS_PER_CORE,
  parameter int unsigned WEIGHT_WIDTH = 4
);
  localparam int unsigned IdxW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [NUM_THREADS-1:0]  request;
  logic                    update_en;
  logic                    weight_wr_en;
  logic [IdxW-1:0]         weight_wr_thread;
  logic [WEIGHT_WIDTH-1:0] weight_wr_value;
  logic [NUM_THREADS-1:0]  grant_oh;
  logic [IdxW-1:0]         grant_idx;
  logic                    grant_valid;
  logic                    perf_starve_override;

  modport master (
    output request, update_en, weight_wr_en, weight_wr_thread, weight_wr_value,
    input  grant_oh, grant_idx, grant_valid, perf_starve_override
  );

  modport slave (
    input  request, update_en, weight_wr_en, weight_wr_thread, weight_wr_value,
    output grant_oh, grant_idx, grant_valid, perf_starve_override
  );
endinterface

// File: rtl/thread_issue_arbiter.sv
// Weighted round-robin thread issue arbiter with starvation override.
// Grant is combinational from the request vector and the registered
// credit/wait/pointer state; the state advances only when update_en is high.
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

module thread_issue_arbiter #(
  parameter int unsigned NUM_THREADS  = `THREADS_PER_CORE,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input logic                      clk,
  input logic                      reset,
  thread_issue_arbiter_if.slave    bus
);

  localparam int unsigned IdxW  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned WaitW = 5;

  localparam logic [WaitW-1:0]        WaitMax   = '1;
  localparam logic [WaitW-1:0]        StarveThr = WaitW'(STARVE_LIMIT);
  localparam logic [WEIGHT_WIDTH-1:0] WeightOne = WEIGHT_WIDTH'(1);
  localparam logic [WaitW-1:0]        WaitOne   = WaitW'(1);

  // Architectural state
  logic [WEIGHT_WIDTH-1:0] weight_q [NUM_THREADS];
  logic [WEIGHT_WIDTH-1:0] weight_d [NUM_THREADS];
  logic [WEIGHT_WIDTH-1:0] credit_q [NUM_THREADS];
  logic [WEIGHT_WIDTH-1:0] credit_d [NUM_THREADS];
  logic [WaitW-1:0]        wait_q   [NUM_THREADS];
  logic [WaitW-1:0]        wait_d   [NUM_THREADS];
  logic [IdxW-1:0]         last_q, last_d;
  logic                    perf_q, perf_d;

  // Arbitration signals
  logic [NUM_THREADS-1:0]  starved;
  logic [NUM_THREADS-1:0]  credited;
  logic [NUM_THREADS-1:0]  eligible;
  logic                    is_override;
  logic                    is_refill;
  logic                    found;
  logic [IdxW-1:0]         winner;
  logic [NUM_THREADS-1:0]  grant_oh_c;
  logic                    commit;
  logic [WEIGHT_WIDTH-1:0] wr_value_eff;

  // Pick the eligible set: starved threads first, then threads holding
  // credit, and finally any requester (which triggers a credit refill).
  always_comb begin
    starved     = '0;
    credited    = '0;
    eligible    = '0;
    is_override = 1'b0;
    is_refill   = 1'b0;
    for (int n = 0; n < int'(NUM_THREADS); n++) begin
      starved[n]  = bus.request[n] && (wait_q[n] >= StarveThr);
      credited[n] = bus.request[n] && (credit_q[n] != '0);
    end
    if (|starved) begin
      eligible    = starved;
      is_override = 1'b1;
    end else if (|credited) begin
      eligible = credited;
    end else begin
      eligible  = bus.request;
      is_refill = |bus.request;
    end
  end

  // Round-robin scan of the eligible set starting just after last_q.
  always_comb begin
    int unsigned k;
    k      = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      k = (32'(last_q) + i) % NUM_THREADS;
      if (!found && eligible[k]) begin
        found  = 1'b1;
        winner = IdxW'(k);
      end
    end
  end

  // One-hot expansion of the winner.
  always_comb begin
    grant_oh_c = '0;
    if (found) begin
      grant_oh_c[winner] = 1'b1;
    end
  end

  assign bus.grant_oh             = grant_oh_c;
  assign bus.grant_idx            = winner;
  assign bus.grant_valid          = found;
  assign bus.perf_starve_override = perf_q;

  assign commit       = bus.update_en && found;
  // A zero weight would lock a thread out of the credited set forever.
  assign wr_value_eff = (bus.weight_wr_value == '0) ? WeightOne : bus.weight_wr_value;

  // Next-state for credits, wait counters, pointer and the override pulse.
  always_comb begin
    last_d = commit ? winner : last_q;
    perf_d = commit && is_override;
    for (int n = 0; n < int'(NUM_THREADS); n++) begin
      weight_d[n] = weight_q[n];
      credit_d[n] = credit_q[n];
      wait_d[n]   = wait_q[n];

      if (commit) begin
        if (is_refill) begin
          // The refill grant itself consumes one of the winner's fresh credits.
          credit_d[n] = grant_oh_c[n] ? (weight_q[n] - WeightOne) : weight_q[n];
        end else if (grant_oh_c[n] && (credit_q[n] != '0)) begin
          // Override grants may land on a zero-credit thread; hold it at zero.
          credit_d[n] = credit_q[n] - WeightOne;
        end
      end

      if (bus.update_en) begin
        if (grant_oh_c[n] || !bus.request[n]) begin
          wait_d[n] = '0;
        end else if (wait_q[n] != WaitMax) begin
          wait_d[n] = wait_q[n] + WaitOne;
        end
      end

      // Software weight write overrides any credit change from this cycle.
      if (bus.weight_wr_en && (bus.weight_wr_thread == IdxW'(n))) begin
        weight_d[n] = wr_value_eff;
        credit_d[n] = wr_value_eff;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < int'(NUM_THREADS); n++) begin
        weight_q[n] <= WeightOne;
        credit_q[n] <= WeightOne;
        wait_q[n]   <= '0;
      end
      // Start the pointer at the top so thread 0 wins the first grant.
      last_q <= IdxW'(NUM_THREADS - 1);
      perf_q <= 1'b0;
    end else begin
      weight_q <= weight_d;
      credit_q <= credit_d;
      wait_q   <= wait_d;
      last_q   <= last_d;
      perf_q   <= perf_d;
    end
  end

endmodule

// File: tb/tb_thread_issue_arbiter.sv
// Scoreboard bench for thread_issue_arbiter: the driver applies stimulus,
// runs a behavioural model and queues expected responses; the monitor pops
// and compares them on the falling edge.
module tb_thread_issue_arbiter;

  localparam int N     = 4;
  localparam int WW    = 4;
  localparam int LIMIT = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  thread_issue_arbiter_if #(.NUM_THREADS(N), .WEIGHT_WIDTH(WW)) bus ();

  thread_issue_arbiter #(
    .NUM_THREADS (N),
    .WEIGHT_WIDTH(WW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0] oh;
    int           idx;
    logic         valid;
    logic         perf;
    int           fixed;
    int           phase;
    int           pend;
    logic [N-1:0] req;
    logic         upd;
  } exp_t;

  exp_t exp_q[$];
  int   phase = 0;
  bit   done  = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state
  int m_weight[N];
  int m_credit[N];
  int m_wait[N];
  int m_last;
  bit m_perf;

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_weight[n] = 1;
      m_credit[n] = 1;
      m_wait[n]   = 0;
    end
    m_last = N - 1;
    m_perf = 1'b0;
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic upd,
                       input logic wen, input int wthr, input int wval,
                       input int fixed, input int pend);
    exp_t e;
    bit   elig[N];
    bit   any_st, any_cr, ovr, refill, found;
    int   win, c, v;
    @(posedge clk);
    #1;
    reset                = rst;
    bus.request          = req;
    bus.update_en        = upd;
    bus.weight_wr_en     = wen;
    bus.weight_wr_thread = 2'(wthr);
    bus.weight_wr_value  = 4'(wval);
    if (!rst) model_reset();

    any_st = 1'b0;
    any_cr = 1'b0;
    for (int n = 0; n < N; n++) begin
      if (req[n] && m_wait[n] >= LIMIT) any_st = 1'b1;
      if (req[n] && m_credit[n] > 0) any_cr = 1'b1;
    end
    for (int n = 0; n < N; n++) begin
      if (any_st)      elig[n] = req[n] && (m_wait[n] >= LIMIT);
      else if (any_cr) elig[n] = req[n] && (m_credit[n] > 0);
      else             elig[n] = req[n];
    end
    ovr    = any_st;
    refill = !any_st && !any_cr && (req != '0);
    found  = 1'b0;
    win    = 0;
    for (int off = 1; off <= N; off++) begin
      c = (m_last + off) % N;
      if (!found && elig[c]) begin
        found = 1'b1;
        win   = c;
      end
    end

    e.oh    = found ? 4'(1 << win) : 4'(0);
    e.idx   = win;
    e.valid = found;
    e.perf  = m_perf;
    e.fixed = fixed;
    e.phase = phase;
    e.pend  = pend;
    e.req   = req;
    e.upd   = upd;
    exp_q.push_back(e);

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_perf = upd && found && ovr;
      if (upd) begin
        for (int n = 0; n < N; n++) begin
          if ((found && n == win) || !req[n]) m_wait[n] = 0;
          else if (m_wait[n] < 31)            m_wait[n] = m_wait[n] + 1;
        end
      end
      if (upd && found) begin
        m_last = win;
        if (refill) begin
          for (int n = 0; n < N; n++) m_credit[n] = m_weight[n];
          m_credit[win] = m_weight[win] - 1;
        end else if (m_credit[win] > 0) begin
          m_credit[win] = m_credit[win] - 1;
        end
      end
      if (wen) begin
        v = (wval == 0) ? 1 : wval;
        m_weight[wthr] = v;
        m_credit[wthr] = v;
      end
    end
  endtask

  task automatic idle_rst();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, -1, 0);
  endtask

  // Stimulus
  initial begin
    int fix1[6]  = '{0, 1, 2, 3, 0, 1};
    int fix2[12] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 0};
    reset                = 1'b0;
    bus.request          = '0;
    bus.update_en        = 1'b0;
    bus.weight_wr_en     = 1'b0;
    bus.weight_wr_thread = '0;
    bus.weight_wr_value  = '0;
    model_reset();

    // Plain round-robin out of reset
    phase = 10;
    idle_rst();
    idle_rst();
    phase = 1;
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, fix1[i], 0);

    // Weights {3,1,1,1}
    phase = 20;
    idle_rst();
    drive(1'b1, 4'b0000, 1'b1, 1'b1, 0, 3, -1, 0);
    phase = 2;
    for (int i = 0; i < 60; i++)
      drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, (i < 12) ? fix2[i] : -1, (i == 59) ? 1 : 0);

    // Starvation override: weights {15,1,1,1}, threads 0 and 1 requesting
    phase = 30;
    idle_rst();
    drive(1'b1, 4'b0000, 1'b1, 1'b1, 0, 15, -1, 0);
    phase = 3;
    for (int i = 0; i < 60; i++)
      drive(1'b1, 4'b0011, 1'b1, 1'b0, 0, 0, -1, (i == 59) ? 2 : 0);

    // Sparse and stalled requests
    phase = 4;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 1'b1, 1'b0, 0, 0, -1, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b0101, 1'b0, 1'b0, 0, 0, -1, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'b0101, 1'b1, 1'b0, 0, 0, -1, 0);

    // Zero-valued weight write to thread 2 in the cycle it is granted
    phase = 50;
    idle_rst();
    phase = 5;
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, 1, 0);
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 2, 0, 2, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, -1, 0);

    // Reset in the middle of a weighted sequence
    phase = 60;
    idle_rst();
    drive(1'b1, 4'b0000, 1'b1, 1'b1, 0, 3, -1, 0);
    phase = 6;
    for (int i = 0; i < 7; i++) drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, -1, 0);
    drive(1'b0, 4'b1111, 1'b1, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, 0, 0);

    // Randomised traffic, weight writes, stalls and occasional reset
    phase = 7;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 199) != 0), 4'($urandom), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)), -1, 0);
    end

    done = 1'b1;
    #500;
    $display("FAIL watchdog: monitor did not drain, %0d entries left (required 0)",
             exp_q.size());
    $fatal(1, "scoreboard did not drain");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_cmp++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, required at most %0d at %0t", name, act, lim, $time);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_cmp++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, required at least %0d at %0t", name, act, lim, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t r;
    int   cnt[N];
    int   run1, max_run1, perf_obs, perf_exp;
    int   cur_phase;
    cur_phase = -1;
    run1 = 0; max_run1 = 0; perf_obs = 0; perf_exp = 0;
    for (int n = 0; n < N; n++) cnt[n] = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        if (r.phase != cur_phase) begin
          cur_phase = r.phase;
          for (int n = 0; n < N; n++) cnt[n] = 0;
          run1 = 0; max_run1 = 0; perf_obs = 0; perf_exp = 0;
        end

        check("grant_oh", int'(bus.grant_oh), int'(r.oh));
        check("grant_idx", int'(bus.grant_idx), r.idx);
        check("grant_valid", int'(bus.grant_valid), int'(r.valid));
        check("perf_starve_override", int'(bus.perf_starve_override), int'(r.perf));
        if (r.fixed >= 0) check("fixed_sequence", int'(bus.grant_idx), r.fixed);

        if (bus.grant_valid && r.upd) cnt[bus.grant_idx]++;
        if (r.upd) begin
          if (r.req[1] && !(bus.grant_valid && bus.grant_idx == 2'd1)) run1++;
          else run1 = 0;
        end
        if (run1 > max_run1) max_run1 = run1;
        perf_obs += int'(bus.perf_starve_override);
        perf_exp += int'(r.perf);

        if (r.pend == 1) begin
          check("weighted_count_t0", cnt[0], 30);
          check("weighted_count_t1", cnt[1], 10);
          check("weighted_count_t2", cnt[2], 10);
          check("weighted_count_t3", cnt[3], 10);
        end
        if (r.pend == 2) begin
          check_le("starve_wait_bound_t1", max_run1, LIMIT + N - 1);
          check("override_pulse_count", perf_obs, perf_exp);
          check_ge("override_pulses_seen", perf_obs, 1);
        end
      end else if (done) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

endmodule

// File: doc/thread_issue_arbiter.md
# thread_issue_arbiter

Weighted round-robin issue arbiter with starvation protection that picks which hardware thread issues each cycle in the thread select stage. It takes the per-thread "can issue" request vector and returns a one-hot grant in the same cycle. Per-thread issue credits let software-programmed weights bias issue bandwidth, and per-thread wait counters bound how long any ready thread can be passed over.

## Interface
Parameters:
- NUM_THREADS, default `THREADS_PER_CORE: number of requesters.
- WEIGHT_WIDTH, default 4: width of weight and credit fields.
- STARVE_LIMIT, default 15: wait-cycle count at which a thread gets priority override (1..2^5-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; state is reset while 0.
- request  in  NUM_THREADS  thread n is ready to issue this cycle.
- update_en  in  1  commit the arbitration result (credits, pointer, wait counters) at the clock edge.
- weight_wr_en  in  1  write one thread's weight.
- weight_wr_thread  in  $clog2(NUM_THREADS)  target thread.
- weight_wr_value  in  WEIGHT_WIDTH  new weight; 0 is treated as 1.
- grant_oh  out  NUM_THREADS  combinational one-hot grant, zero when request==0.
- grant_idx  out  $clog2(NUM_THREADS)  index of grant_oh; 0 when no grant.
- grant_valid  out  1  |grant_oh.
- perf_starve_override  out  1  registered; pulses the cycle after a committed override grant.

## Operation
- State per thread: weight[n] (reset 1), credit[n] (reset 1), wait_cnt[n] (5 bits, reset 0). Shared state: last_grant (reset NUM_THREADS-1, so thread 0 wins first). Registered output perf_starve_override resets to 0.
- starved = request & (wait_cnt >= STARVE_LIMIT).
- Eligible set selection, in priority order:
  - If starved != 0: eligible = starved, and the grant is an override.
  - Else if (request & credit!=0) != 0: eligible = request & credit!=0.
  - Else if request != 0: eligible = request, and the grant is a refill.
  - Else: no grant.
- Within the eligible set, the winner is the first set bit scanning upward from last_grant+1, wrapping modulo NUM_THREADS.
- Commit happens when update_en && grant_valid:
  - last_grant <= winner.
  - Refill grant: every credit[n] <= weight[n]; the winner's credit is loaded with weight-1.
  - Normal grant: credit[winner] decrements by 1.
  - Override grant: credit[winner] decrements if nonzero and otherwise stays 0. An override never refills.
- Wait counters update when update_en is high:
  - Granted thread or non-requesting thread: wait_cnt is cleared.
  - Requesting thread that is not granted: wait_cnt increments, saturating at 31.
- When update_en is low, no state changes, but grant_oh is still driven.
- Weight write: weight[t] and credit[t] are loaded with max(value,1) at the edge.
  - If the same thread is also committed that cycle, the weight write wins for credit.
  - A weight write takes precedence over a refill for the written thread.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The grant is combinational from reset-valued state.

## Timing
- Request to grant is zero latency (combinational). Grant to state update is one clock edge.
- perf_starve_override is high exactly one cycle after each committed override grant.
- Worst-case wait for a continuously requesting thread, with update_en always high: STARVE_LIMIT + NUM_THREADS - 1 cycles.
- With all weights 1, behaviour is identical to plain round-robin.

## Test plan
- Reset, all weights 1, request=4'b1111, update_en=1 -> grants 0,1,2,3,0,1 and perf_starve_override stays 0.
- Write weights {3,1,1,1}, request=4'b1111 for 60 cycles -> sequence starts 0,1,2,3,0,0,1,2,3,0,0,0; thread 0 gets 30 grants and threads 1, 2, 3 get 10 each.
- STARVE_LIMIT=4, weights {15,1,1,1}, request=4'b0011 -> thread 1 is never passed over more than 4 consecutive cycles; perf_starve_override pulses one cycle after each override grant.
- Sparse and stalled requests:
  - request=0 -> grant_valid=0 and no state change.
  - Hold update_en=0 with request=4'b0101 for 5 cycles -> grant_oh stays at the same value and wait_cnt does not advance.
- Weight write with value 0 to thread 2 while thread 2 is granted that cycle -> weight and credit read back as 1, and the following grants match plain round-robin.
- Drive reset low in the middle of a weighted sequence -> next grant with request=4'b1111 is thread 0 and perf_starve_override is 0.
